// File: rtl/player_status.sv
// rtl/player_status.sv - player life/money bookkeeping with life bar and 4-digit 7-seg scan
//
// Tracks the player's remaining lives and money from the hit/damage/ticket
// pulses and the top-level game state. Drives the fail flag, a 10-LED
// thermometer life bar and a multiplexed 4-digit 7-segment display
// (money on the right two digits, lives on the left two).
//
// Optional feature: define COMBO_BONUS_EN to award +1 money every COMBO_LEN
// consecutive hits in play (any damage breaks the streak).
//
// Ports:
//   clk          in   1   system clock
//   rst          in   1   asynchronous active-high reset
//   state        in   4   game state: 0 GAMESTART, 1 EASY, 2 NORMAL, 3 HARD, 5 FAILURE
//   hit_0..2     in   1   one-cycle pulse, enemy hit in lane n
//   damage_0..2  in   1   one-cycle pulse, enemy reached player in lane n
//   ticket       in   1   one-cycle pulse, purchase request
//   life         out  10  thermometer life bar, bit i lit iff lives > i
//   fail         out  1   play state with no lives left
//   total_money  out  7   current money
//   display      out  7   segments {g,f,e,d,c,b,a}, active-low
//   digit        out  4   digit enables, active-low, digit[0] rightmost
module player_status #(
    parameter int LIFE_MAX     = 10,
    parameter int MONEY_INIT   = 10,
    parameter int MONEY_MAX    = 99,
    parameter int TICKET_COST  = 5,
    parameter int REFRESH_BITS = 17,
    parameter int COMBO_LEN    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] state,
    input  logic       hit_0,
    input  logic       hit_1,
    input  logic       hit_2,
    input  logic       damage_0,
    input  logic       damage_1,
    input  logic       damage_2,
    input  logic       ticket,
    output logic [9:0] life,
    output logic       fail,
    output logic [6:0] total_money,
    output logic [6:0] display,
    output logic [3:0] digit
);

    localparam logic [3:0] ST_GAMESTART = 4'd0;
    localparam logic [3:0] ST_EASY      = 4'd1;
    localparam logic [3:0] ST_NORMAL    = 4'd2;
    localparam logic [3:0] ST_HARD      = 4'd3;

    logic [3:0]              prev_state;
    logic [3:0]              life_cnt;
    logic [6:0]              money;
    logic [REFRESH_BITS-1:0] scan_cnt;

    logic       play;
    logic       entry;
    logic [1:0] hit_n;
    logic [1:0] dmg_n;
    logic [3:0] gain;
    logic [3:0] life_next;
    logic [7:0] money_sum;
    logic [6:0] money_hit;
    logic       combo_bonus;

    assign play  = (state == ST_EASY) || (state == ST_NORMAL) || (state == ST_HARD);
    assign entry = play && (prev_state == ST_GAMESTART);
    assign hit_n = {1'b0, hit_0} + {1'b0, hit_1} + {1'b0, hit_2};
    assign dmg_n = {1'b0, damage_0} + {1'b0, damage_1} + {1'b0, damage_2};

    always_comb begin
        gain = 4'd0;
        case (state)
            ST_EASY:   gain = {2'b00, hit_n};
            ST_NORMAL: gain = {1'b0, hit_n, 1'b0};
            ST_HARD:   gain = {2'b00, hit_n} + {1'b0, hit_n, 1'b0};
            default:   gain = 4'd0;
        endcase
    end

    // Life floors at zero even when several lanes damage in one cycle.
    assign life_next = ({2'b00, dmg_n} >= life_cnt) ? 4'd0 : life_cnt - {2'b00, dmg_n};

    assign money_sum = {1'b0, money} + {4'b0000, gain} + {7'd0, combo_bonus};
    assign money_hit = (money_sum >= 8'(MONEY_MAX)) ? 7'(MONEY_MAX) : money_sum[6:0];

`ifdef COMBO_BONUS_EN
    localparam int CW = $clog2(COMBO_LEN + 3);
    logic [CW-1:0] combo;
    logic [CW-1:0] combo_sum;

    assign combo_sum   = combo + CW'(hit_n);
    // A damaged cycle breaks the streak, so its hits never complete a combo.
    assign combo_bonus = play && !entry && (dmg_n == 2'd0) && (combo_sum >= CW'(COMBO_LEN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            combo <= '0;
        end else if (entry || (play && dmg_n != 2'd0)) begin
            combo <= '0;
        end else if (play) begin
            combo <= combo_bonus ? combo_sum - CW'(COMBO_LEN) : combo_sum;
        end
    end
`else
    assign combo_bonus = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_state <= ST_GAMESTART;
            life_cnt   <= 4'(LIFE_MAX);
            money      <= 7'(MONEY_INIT);
        end else begin
            prev_state <= state;
            if (play) begin
                // A fresh game reload wins over damage arriving the same cycle.
                life_cnt <= entry ? 4'(LIFE_MAX) : life_next;
                money    <= money_hit;
            end else if (state == ST_GAMESTART && ticket && money >= 7'(TICKET_COST)) begin
                money <= money - 7'(TICKET_COST);
            end
        end
    end

    always_comb begin
        life = '0;
        for (int i = 0; i < 10; i++) begin
            life[i] = (life_cnt > 4'(i));
        end
    end

    assign fail        = play && (life_cnt == 4'd0);
    assign total_money = money;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    logic [1:0] sel;
    logic [3:0] money_tens, money_ones, life_tens, life_ones;
    logic [3:0] digit_val;

    assign sel        = scan_cnt[REFRESH_BITS-1 -: 2];
    assign money_tens = 4'(money / 7'd10);
    assign money_ones = 4'(money % 7'd10);
    assign life_tens  = (life_cnt >= 4'd10) ? 4'd1 : 4'd0;
    assign life_ones  = (life_cnt >= 4'd10) ? life_cnt - 4'd10 : life_cnt;

    always_comb begin
        digit_val = 4'd0;
        case (sel)
            2'd0: digit_val = money_ones;
            2'd1: digit_val = money_tens;
            2'd2: digit_val = life_ones;
            2'd3: digit_val = life_tens;
            default: digit_val = 4'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            digit    <= 4'b1110;
            display  <= 7'b1000000;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
            digit    <= ~(4'b0001 << sel);
            display  <= seg7(digit_val);
        end
    end

endmodule

// File: tb/tb_player_status.sv
// tb/tb_player_status.sv - scoreboard bench for player_status
module tb_player_status;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] state;
    logic       hit_0, hit_1, hit_2;
    logic       damage_0, damage_1, damage_2;
    logic       ticket;
    logic [9:0] life;
    logic       fail;
    logic [6:0] total_money;
    logic [6:0] display;
    logic [3:0] digit;

    player_status #(.REFRESH_BITS(4)) dut (
        .clk(clk), .rst(rst), .state(state),
        .hit_0(hit_0), .hit_1(hit_1), .hit_2(hit_2),
        .damage_0(damage_0), .damage_1(damage_1), .damage_2(damage_2),
        .ticket(ticket), .life(life), .fail(fail), .total_money(total_money),
        .display(display), .digit(digit)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind 0: status, 1: status + reset display, 2: scan sample, 3: scan coverage
    typedef struct {
        int              stamp;
        int              kind;
        string           name;
        logic [9:0]      life;
        logic [6:0]      money;
        logic            fail;
        logic [3:0][6:0] segs;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    exp_t e;
    logic [3:0] seen = 4'h0;
    logic [6:0] want_seg;
    logic       bad_digit;

    always @(negedge clk) begin
        while (q.size() != 0 && q[0].stamp <= cyc) begin
            e = q.pop_front();
            vectors++;
            case (e.kind)
                0, 1: begin
                    if (life !== e.life || total_money !== e.money || fail !== e.fail ||
                        (e.kind == 1 && (digit !== 4'b1110 || display !== 7'b1000000))) begin
                        miscompares++;
                        $display("FAIL %s: got life=%h money=%0d fail=%b digit=%b display=%b, want life=%h money=%0d fail=%b%s",
                                 e.name, life, total_money, fail, digit, display,
                                 e.life, e.money, e.fail, (e.kind == 1) ? " digit=1110 display=1000000" : "");
                    end
                end
                2: begin
                    bad_digit = 1'b0;
                    want_seg  = 7'h7F;
                    case (digit)
                        4'b1110: want_seg = e.segs[0];
                        4'b1101: want_seg = e.segs[1];
                        4'b1011: want_seg = e.segs[2];
                        4'b0111: want_seg = e.segs[3];
                        default: bad_digit = 1'b1;
                    endcase
                    seen = seen | ~digit;
                    if (bad_digit || display !== want_seg) begin
                        miscompares++;
                        $display("FAIL %s: got digit=%b display=%b, want one-hot-low digit with display=%b",
                                 e.name, digit, display, want_seg);
                    end
                end
                default: begin
                    if (seen !== 4'hF) begin
                        miscompares++;
                        $display("FAIL %s: got digits seen=%b, want 1111", e.name, seen);
                    end
                    seen = 4'h0;
                end
            endcase
        end
    end

    task automatic push(input int kind, input string n, input logic [9:0] l,
                        input logic [6:0] m, input logic f);
        exp_t x;
        x.stamp = cyc; x.kind = kind; x.name = n;
        x.life = l; x.money = m; x.fail = f; x.segs = '0;
        q.push_back(x);
    endtask

    task automatic expect_st(input string n, input logic [9:0] l,
                             input logic [6:0] m, input logic f);
        push(0, n, l, m, f);
    endtask

    task automatic clear_pulses();
        {hit_2, hit_1, hit_0} = 3'b000;
        {damage_2, damage_1, damage_0} = 3'b000;
        ticket = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] st, input logic [2:0] h,
                         input logic [2:0] d, input logic t);
        @(posedge clk); #1;
        state = st;
        {hit_2, hit_1, hit_0} = h;
        {damage_2, damage_1, damage_0} = d;
        ticket = t;
        @(posedge clk); #1;
        clear_pulses();
    endtask

    task automatic set_state(input logic [3:0] st);
        @(posedge clk); #1;
        state = st;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        exp_t x;
        rst = 1'b1;
        state = 4'd0;
        clear_pulses();
        repeat (2) @(posedge clk);
        #1;
        push(1, "reset", 10'h3FF, 7'd10, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // NORMAL hits: +2 each
        set_state(4'd2);
        expect_st("enter_normal", 10'h3FF, 7'd10, 1'b0);
        pulse(4'd2, 3'b001, 3'b000, 1'b0); expect_st("normal_hit1", 10'h3FF, 7'd12, 1'b0);
        pulse(4'd2, 3'b001, 3'b000, 1'b0); expect_st("normal_hit2", 10'h3FF, 7'd14, 1'b0);
        pulse(4'd2, 3'b001, 3'b000, 1'b0); expect_st("normal_hit3", 10'h3FF, 7'd16, 1'b0);

        // GAMESTART ignores hits and damage
        set_state(4'd0);
        pulse(4'd0, 3'b111, 3'b111, 1'b0); expect_st("gs_ignores_hit_dmg", 10'h3FF, 7'd16, 1'b0);

        // EASY: drain all lives with single damage pulses
        set_state(4'd1);
        for (int i = 0; i < 9; i++) pulse(4'd1, 3'b000, 3'b010, 1'b0);
        expect_st("easy_dmg9", 10'h001, 7'd16, 1'b0);
        pulse(4'd1, 3'b000, 3'b010, 1'b0); expect_st("easy_dmg10_fail", 10'h000, 7'd16, 1'b1);
        pulse(4'd1, 3'b000, 3'b010, 1'b0); expect_st("easy_dmg11_sat", 10'h000, 7'd16, 1'b1);

        // HARD: double damage at one life saturates
        set_state(4'd0);
        expect_st("gs_fail_low", 10'h000, 7'd16, 1'b0);
        set_state(4'd3);
        for (int i = 0; i < 9; i++) pulse(4'd3, 3'b000, 3'b001, 1'b0);
        expect_st("hard_life1", 10'h001, 7'd16, 1'b0);
        pulse(4'd3, 3'b000, 3'b101, 1'b0); expect_st("hard_double_sat", 10'h000, 7'd16, 1'b1);

        // tickets
        set_state(4'd0);
        pulse(4'd0, 3'b000, 3'b000, 1'b1); expect_st("ticket_16", 10'h000, 7'd11, 1'b0);
        pulse(4'd0, 3'b000, 3'b000, 1'b1); expect_st("ticket_11", 10'h000, 7'd6, 1'b0);
        pulse(4'd0, 3'b000, 3'b000, 1'b1); expect_st("ticket_6", 10'h000, 7'd1, 1'b0);
        pulse(4'd0, 3'b000, 3'b000, 1'b1); expect_st("ticket_1_denied", 10'h000, 7'd1, 1'b0);
        set_state(4'd1);
        pulse(4'd1, 3'b011, 3'b000, 1'b0); expect_st("easy_hit2", 10'h3FF, 7'd3, 1'b0);
        pulse(4'd1, 3'b000, 3'b000, 1'b1); expect_st("ticket_in_play", 10'h3FF, 7'd3, 1'b0);
        set_state(4'd0);
        pulse(4'd0, 3'b000, 3'b000, 1'b1); expect_st("ticket_3_denied", 10'h3FF, 7'd3, 1'b0);
        set_state(4'd1);
        pulse(4'd1, 3'b011, 3'b000, 1'b0); expect_st("easy_to_5", 10'h3FF, 7'd5, 1'b0);
        set_state(4'd0);
        pulse(4'd0, 3'b000, 3'b000, 1'b1); expect_st("ticket_exact_5", 10'h3FF, 7'd0, 1'b0);
        set_state(4'd2);
        pulse(4'd2, 3'b111, 3'b000, 1'b0); expect_st("normal_hit_x3", 10'h3FF, 7'd6, 1'b0);
        pulse(4'd2, 3'b010, 3'b000, 1'b0);
        pulse(4'd2, 3'b100, 3'b000, 1'b0); expect_st("normal_to_10", 10'h3FF, 7'd10, 1'b0);
        set_state(4'd0);
        pulse(4'd0, 3'b000, 3'b000, 1'b1); expect_st("ticket_10", 10'h3FF, 7'd5, 1'b0);

        // HARD gain and saturation
        set_state(4'd3);
        for (int i = 0; i < 10; i++) pulse(4'd3, 3'b111, 3'b000, 1'b0);
        expect_st("hard_x3_to_95", 10'h3FF, 7'd95, 1'b0);
        pulse(4'd1, 3'b001, 3'b000, 1'b0); expect_st("easy_to_96", 10'h3FF, 7'd96, 1'b0);

        // display scan: money 96, lives 10
        x.kind = 2; x.name = "scan"; x.life = '0; x.money = '0; x.fail = 1'b0;
        x.segs[0] = 7'b0000010;
        x.segs[1] = 7'b0010000;
        x.segs[2] = 7'b1000000;
        x.segs[3] = 7'b1111001;
        for (int i = 0; i < 16; i++) begin
            x.stamp = cyc + i;
            q.push_back(x);
        end
        x.kind = 3; x.name = "scan_cover"; x.stamp = cyc + 15;
        q.push_back(x);
        repeat (16) @(posedge clk);
        #1;

        pulse(4'd2, 3'b001, 3'b000, 1'b0); expect_st("normal_to_98", 10'h3FF, 7'd98, 1'b0);
        pulse(4'd3, 3'b011, 3'b000, 1'b0); expect_st("hard_sat_99", 10'h3FF, 7'd99, 1'b0);
        for (int i = 0; i < 3; i++) pulse(4'd3, 3'b000, 3'b111, 1'b0);
        expect_st("hard_triple_dmg", 10'h001, 7'd99, 1'b0);
        pulse(4'd3, 3'b000, 3'b111, 1'b0); expect_st("hard_triple_sat", 10'h000, 7'd99, 1'b1);
        set_state(4'd5);
        expect_st("failure_no_fail", 10'h000, 7'd99, 1'b0);
        pulse(4'd5, 3'b111, 3'b111, 1'b1); expect_st("failure_holds", 10'h000, 7'd99, 1'b0);
        set_state(4'd0);
        pulse(4'd1, 3'b000, 3'b111, 1'b0); expect_st("reload_beats_damage", 10'h3FF, 7'd99, 1'b0);

        // asynchronous reset mid-cycle with pulses pending
        @(posedge clk); #1;
        {hit_2, hit_1, hit_0} = 3'b111;
        {damage_2, damage_1, damage_0} = 3'b111;
        #2 rst = 1'b1;
        push(1, "async_reset", 10'h3FF, 7'd10, 1'b0);
        @(posedge clk); #1;
        clear_pulses();
        rst = 1'b0;
        pulse(4'd1, 3'b001, 3'b000, 1'b0); expect_st("after_reset_hit", 10'h3FF, 7'd11, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
